// File: rtl/mod_muldiv_pkg.sv
// Shared encodings for the iterative mult/div sequencer.
// Optional feature macro: MULDIV_EARLY_EXIT_EN (see mod_muldiv_ctrl).
package mod_muldiv_pkg;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic int cnt_width(int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DATA_W_DEF);
endpackage

// File: rtl/mod_muldiv_ctrl_if.sv
// EX-stage <-> mult/div sequencer bus: operation request, HI/LO access, status.
interface mod_muldiv_ctrl_if #(parameter int DATA_W = 32);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              hilo_rd;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hilo_rd, hi_we, lo_we, wdata,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hilo_rd, hi_we, lo_we, wdata,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mod_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the {hi,lo} accumulator.
module mod_muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] hi_nxt,
  output logic [DATA_W-1:0] lo_nxt
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[DATA_W-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      // partial remainder stays below the divisor, so diff's top bit is its sign
      if (!diff[DATA_W]) begin
        hi_nxt = diff[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[DATA_W:1];
      lo_nxt = {sum[0], lo[DATA_W-1:1]};
    end
  end
endmodule

// File: rtl/mod_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; requests pipeline stall while busy.
// Define MULDIV_EARLY_EXIT_EN to end multiplies once the remaining multiplier bits are zero.
module mod_muldiv_ctrl
  import mod_muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  mod_muldiv_ctrl_if.slave bus
);
  localparam int CW = cnt_width(DATA_W);

  state_e              state;
  logic [CW-1:0]       cnt;
  logic                is_div;
  logic                neg_lo;
  logic                neg_hi;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic [DATA_W-1:0]   hi_nxt;
  logic [DATA_W-1:0]   lo_nxt;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [2*DATA_W-1:0] prod;
  logic                signed_op;
  logic                div_op;
  logic                a_neg;
  logic                b_neg;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [DATA_W-1:0]   mplr;
  logic [CW-1:0]       shamt;
`endif

  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    a_neg     = signed_op & bus.src_a[DATA_W-1];
    b_neg     = signed_op & bus.src_b[DATA_W-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    mag_a     = a_neg ? -bus.src_a : bus.src_a;
    mag_b     = b_neg ? -bus.src_b : bus.src_b;
    prod      = {acc_hi, acc_lo};
  end

  mod_muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div (is_div),
    .hi     (acc_hi),
    .lo     (acc_lo),
    .opnd   (opnd),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

`ifdef MULDIV_EARLY_EXIT_EN
  assign shamt = CW'(DATA_W - 1) - cnt;
`endif

  assign bus.busy  = (state != ST_IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.hilo_rd | bus.hi_we | bus.lo_we);
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
`ifdef MULDIV_EARLY_EXIT_EN
      mplr   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.start) begin
            is_div <= div_op;
            if (div_op) begin
              opnd <= mag_b;
              if (bus.src_b == '0) begin
                // divide by zero: FIX passes these through untouched
                acc_hi <= bus.src_a;
                acc_lo <= '1;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                state  <= ST_FIX;
              end else begin
                acc_hi <= '0;
                acc_lo <= mag_a;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                state  <= ST_CALC;
              end
            end else begin
              opnd   <= mag_a;
              acc_hi <= '0;
              acc_lo <= mag_b;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg ^ b_neg;
              state  <= ST_CALC;
            end
`ifdef MULDIV_EARLY_EXIT_EN
            mplr <= mag_b;
`endif
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        ST_CALC: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(DATA_W - 1)) state <= ST_FIX;
`ifdef MULDIV_EARLY_EXIT_EN
          mplr <= mplr >> 1;
          if (!is_div && ((mplr >> 1) == '0)) begin
            {acc_hi, acc_lo} <= {hi_nxt, lo_nxt} >> shamt;
            state            <= ST_FIX;
          end
`endif
        end
        ST_FIX: begin
          if (is_div) begin
            lo_r <= neg_lo ? -acc_lo : acc_lo;
            hi_r <= neg_hi ? -acc_hi : acc_hi;
          end else begin
            {hi_r, lo_r} <= neg_lo ? -prod : prod;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_muldiv_ctrl.sv
// Scoreboard bench for mod_muldiv_ctrl: stimulus pushes model results, a monitor checks on busy fall.
module tb_mod_muldiv_ctrl;
  import mod_muldiv_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_muldiv_ctrl_if #(.DATA_W(W)) bus();
  mod_muldiv_ctrl #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           blen;
    bit           chk_len;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like the ISA.
  function automatic exp_t model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    longint unsigned ua, ub, up;
    logic [W-1:0] m;
    int k;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.chk_len = 1'b1;
    e.blen = W + 1;
    case (op)
      OP_MULT: begin
        q = sa * sbv;
        e.hi = q[63:32];
        e.lo = q[31:0];
      end
      OP_MULTU: begin
        up = ua * ub;
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
        if (b == 0) begin
          e.hi = a;
          e.lo = '1;
          e.blen = 1;
        end else if (op == OP_DIV) begin
          q = sa / sbv;
          r = sa % sbv;
          e.hi = r[31:0];
          e.lo = q[31:0];
        end else begin
          up = ua / ub;
          e.lo = up[31:0];
          up = ua % ub;
          e.hi = up[31:0];
        end
      end
    endcase
`ifdef MULDIV_EARLY_EXIT_EN
    if (op == OP_MULT || op == OP_MULTU) begin
      m = (op == OP_MULT && b[W-1]) ? -b : b;
      k = 0;
      for (int i = 0; i < W; i++) if (m[i]) k = i;
      e.blen = k + 2;
    end
`else
    m = '0;
    k = 0;
`endif
    return e;
  endfunction

  // Monitor: result is checked in the first idle cycle after busy drops.
  initial begin : mon
    exp_t e;
    int blen_cnt;
    bit prev_busy;
    blen_cnt = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) blen_cnt++;
      else if (prev_busy) begin
        if (sb.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check("hi", bus.hi, e.hi);
          check("lo", bus.lo, e.lo);
          if (e.chk_len) check("busy_len", blen_cnt, e.blen);
        end
        blen_cnt = 0;
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      cyc();
      n++;
    end
    if (bus.busy) check("busy_timeout", bus.busy, 0);
  endtask

  task automatic issue(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    sb.push_back(model(op, a, b));
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic run_op(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    issue(op, a, b);
    wait_idle();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t z;
    logic [W-1:0] a, b, hi_before;
    int n;
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
    bus.hilo_rd = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    rst = 1'b1;
    repeat (3) cyc();
    check("rst_busy", bus.busy, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst = 1'b0;
    cyc();

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(OP_MULT,  32'hFFFFFFFD, 32'd7);
    run_op(OP_MULT,  32'h80000000, 32'h80000000);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2);
    run_op(OP_DIVU,  32'd100, 32'd7);
    run_op(OP_DIVU,  32'd100, 32'd0);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF);
    run_op(OP_DIV,   32'h00000009, 32'hFFFFFFFC);
    run_op(OP_MULTU, 32'd5, 32'd1);
    run_op(OP_MULT,  32'h12345678, 32'd0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        2: b = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(2'($urandom_range(0, 3)), a, b);
    end

    // second start and MFHI while busy must stall, not start
    issue(OP_MULTU, 32'h00001234, 32'h00005678);
    bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd50; bus.src_b = 32'd3;
    bus.hilo_rd = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin
      check("stall_busy", bus.stall, 1);
      cyc();
      n++;
    end
    check("stall_released", bus.stall, 0);
    bus.start = 1'b0;
    bus.hilo_rd = 1'b0;
    cyc();
    check("second_not_started", bus.busy, 0);

    // MTHI/MTLO in idle
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    cyc();
    bus.hi_we = 1'b0;
    check("mthi", bus.hi, 32'h12345678);
    bus.lo_we = 1'b1; bus.wdata = 32'h0BADF00D;
    cyc();
    bus.lo_we = 1'b0;
    check("mtlo", bus.lo, 32'h0BADF00D);

    // start beats a simultaneous MTHI
    hi_before = bus.hi;
    bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    issue(OP_MULTU, 32'd2, 32'd3);
    bus.hi_we = 1'b0;
    check("start_wins_hi", bus.hi, hi_before);
    wait_idle();

    // MTLO during busy stalls, then lands after release
    issue(OP_MULTU, 32'd6, 32'd7);
    bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
    n = 0;
    while (bus.busy && n < 200) begin
      check("mtlo_stall", bus.stall, 1);
      cyc();
      n++;
    end
    cyc();
    bus.lo_we = 1'b0;
    check("mtlo_after", bus.lo, 32'hA5A5A5A5);

    // reset mid-CALC aborts and clears HI/LO
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    void'(sb.pop_back());
    z.hi = '0; z.lo = '0; z.blen = 0; z.chk_len = 1'b0;
    sb.push_back(z);
    repeat (10) cyc();
    bus.hilo_rd = 1'b1;
    #1;
    check("pre_rst_stall", bus.stall, 1);
    rst = 1'b1;
    cyc();
    check("abort_busy", bus.busy, 0);
    check("abort_stall", bus.stall, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    rst = 1'b0;
    bus.hilo_rd = 1'b0;
    cyc();

    run_op(OP_DIVU, 32'd100, 32'd7);
    repeat (3) cyc();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
